conv55_window_ctrl: RTL and testbench

Streaming sequencer that sits in front of the 6-bit 5x5 convolution engine in the LeNet-5 C1 layer. It accepts raster-order pixels through a valid/ready handshake and builds the 5x5 sliding window from four line buffers plus a shift-register window. It marks which windows are legal convolution positions, and it tracks the engine's fixed pipeline latency so downstream logic receives a result-valid strobe with matching output coordinates. It also sequences one frame per start pulse and reports completion.

---
 rtl/conv55_window_ctrl.sv | 156 +++++++++++++++
 tb/tb_conv55_window_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv55_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : conv55_window_ctrl
// Brief   : Raster-order 5x5 window builder and latency tracker for a conv engine.
// Revision: 1.0  initial release
// ============================================================================
module conv55_window_ctrl #(
    parameter int IMAGE_COLS   = 32,
    parameter int IMAGE_ROWS   = 32,
    parameter int IN_WIDTH     = 6,
    parameter int CONV_LATENCY = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [IN_WIDTH-1:0]      nextPixel,
    output logic                     in_ready,
    output logic [25*IN_WIDTH-1:0]   win_data,
    output logic                     win_valid,
    output logic                     conv_valid,
    output logic [4:0]               out_row,
    output logic [4:0]               out_col,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int c_COL_W = (IMAGE_COLS > 1) ? $clog2(IMAGE_COLS) : 1;
    localparam int c_ROW_W = (IMAGE_ROWS > 1) ? $clog2(IMAGE_ROWS) : 1;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_STREAM = 2'd1;
    localparam logic [1:0] c_DRAIN  = 2'd2;

    logic [1:0]          r_state;
    logic [c_ROW_W-1:0]  r_row;
    logic [c_COL_W-1:0]  r_col;
    logic [IN_WIDTH-1:0] r_win [0:4][0:4];
    logic [IN_WIDTH-1:0] r_lb  [0:3][0:IMAGE_COLS-1];

    // Stage 0 is the window-valid register; stage CONV_LATENCY is the engine output.
    logic [CONV_LATENCY:0] r_pv;
    logic [4:0]            r_prow [0:CONV_LATENCY];
    logic [4:0]            r_pcol [0:CONV_LATENCY];

    logic                w_accept;
    logic                w_last_col;
    logic                w_last_row;
    logic                w_win_hit;
    logic                w_pipe_busy;
    logic [4:0]          w_out_row;
    logic [4:0]          w_out_col;

    assign in_ready    = (r_state == c_STREAM);
    assign busy        = (r_state == c_STREAM) || (r_state == c_DRAIN);
    assign w_accept    = in_valid && in_ready;
    assign w_last_col  = (r_col == c_COL_W'(IMAGE_COLS - 1));
    assign w_last_row  = (r_row == c_ROW_W'(IMAGE_ROWS - 1));
    assign w_win_hit   = w_accept && (r_row >= c_ROW_W'(4)) && (r_col >= c_COL_W'(4));
    assign w_pipe_busy = |r_pv;
    assign w_out_row   = 5'(r_row - c_ROW_W'(4));
    assign w_out_col   = 5'(r_col - c_COL_W'(4));
    assign frame_done  = (r_state == c_DRAIN) && !w_pipe_busy;

    assign win_valid   = r_pv[0];
    assign conv_valid  = r_pv[CONV_LATENCY];
    assign out_row     = r_prow[CONV_LATENCY];
    assign out_col     = r_pcol[CONV_LATENCY];

    for (genvar gi = 0; gi < 5; gi++) begin : g_win_row
        for (genvar gj = 0; gj < 5; gj++) begin : g_win_col
            assign win_data[(gi*5+gj)*IN_WIDTH +: IN_WIDTH] = r_win[gi][gj];
        end
    end

    // Line buffers cascade one row down per accepted pixel; reads see pre-write data.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb[0][r_col] <= nextPixel;
            for (int k = 1; k < 4; k++) begin
                r_lb[k][r_col] <= r_lb[k-1][r_col];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_win   <= '{default: '{default: '0}};
            r_pv    <= '0;
            for (int k = 0; k <= CONV_LATENCY; k++) begin
                r_prow[k] <= '0;
                r_pcol[k] <= '0;
            end
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_row   <= '0;
                        r_col   <= '0;
                        r_state <= c_STREAM;
                    end
                end
                c_STREAM: begin
                    if (w_accept) begin
                        if (w_last_col) begin
                            r_col <= '0;
                            r_row <= r_row + c_ROW_W'(1);
                            if (w_last_row) begin
                                r_state <= c_DRAIN;
                            end
                        end else begin
                            r_col <= r_col + c_COL_W'(1);
                        end
                    end
                end
                c_DRAIN: begin
                    if (!w_pipe_busy) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase

            if (w_accept) begin
                for (int i = 0; i < 5; i++) begin
                    for (int j = 0; j < 4; j++) begin
                        r_win[i][j] <= r_win[i][j+1];
                    end
                end
                r_win[0][4] <= nextPixel;
                for (int k = 1; k < 5; k++) begin
                    r_win[k][4] <= r_lb[k-1][r_col];
                end
            end

            r_pv[0] <= w_win_hit;
            if (w_win_hit) begin
                r_prow[0] <= w_out_row;
                r_pcol[0] <= w_out_col;
            end
            // Coordinates only advance with a valid entry, so the output stage holds its last value.
            for (int k = 1; k <= CONV_LATENCY; k++) begin
                r_pv[k] <= r_pv[k-1];
                if (r_pv[k-1]) begin
                    r_prow[k] <= r_prow[k-1];
                    r_pcol[k] <= r_pcol[k-1];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv55_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_conv55_window_ctrl
// Brief   : Directed bench for conv55_window_ctrl with a positional window model.
// Revision: 1.0  initial release
// ============================================================================
module tb_conv55_window_ctrl;

    localparam int c_COLS = 32;
    localparam int c_ROWS = 32;
    localparam int c_W    = 6;
    localparam int c_L    = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic [5:0]   nextPixel = '0;
    logic         in_ready;
    logic [149:0] win_data;
    logic         win_valid;
    logic         conv_valid;
    logic [4:0]   out_row;
    logic [4:0]   out_col;
    logic         busy;
    logic         frame_done;

    conv55_window_ctrl #(
        .IMAGE_COLS  (c_COLS),
        .IMAGE_ROWS  (c_ROWS),
        .IN_WIDTH    (c_W),
        .CONV_LATENCY(c_L)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .nextPixel (nextPixel),
        .in_ready  (in_ready),
        .win_data  (win_data),
        .win_valid (win_valid),
        .conv_valid(conv_valid),
        .out_row   (out_row),
        .out_col   (out_col),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int orow;
        int ocol;
    } cv_t;

    cv_t q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  mode = 0;
    int  pix_r = 0;
    int  pix_c = 0;
    int  n_acc = 0;
    int  n_wdut = 0;
    int  n_fd = 0;
    int  fd_due = -1;
    int  last_or = 0;
    int  last_oc = 0;
    bit  stream_on = 1'b0;

    task automatic chk(input string tag, input logic [149:0] obs, input logic [149:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Mode 1 spans the full 6-bit range so negative pixels are exercised.
    function automatic logic [5:0] pix(input int m, input int r, input int c);
        if (m == 0) return 6'((r + c) % 32);
        return 6'((r * 7 + c * 3 + 5) % 64);
    endfunction

    function automatic logic [149:0] model_win(input int m, input int r, input int c);
        logic [149:0] w;
        w = '0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                w[(i*5+j)*6 +: 6] = pix(m, r - i, c - 4 + j);
            end
        end
        return w;
    endfunction

    task automatic tick(input logic st, input logic v);
        logic acc;
        logic legal;
        logic cv_exp;
        bit   idle;
        int   r;
        int   c;
        int   e;
        chk("in_ready", 150'(in_ready), 150'(stream_on));
        idle      = !stream_on && (fd_due < 0 || cyc > fd_due);
        start     = st;
        in_valid  = v;
        nextPixel = v ? pix(mode, pix_r, pix_c) : 6'($urandom);
        acc   = v && stream_on;
        r     = pix_r;
        c     = pix_c;
        legal = acc && r >= 4 && c >= 4;
        e     = cyc + 1;
        if (acc) begin
            n_acc++;
            if (c == c_COLS - 1) begin
                pix_c = 0;
                pix_r++;
            end else begin
                pix_c++;
            end
            if (r == c_ROWS - 1 && c == c_COLS - 1) begin
                stream_on = 1'b0;
                fd_due    = e + c_L + 1;
            end
        end
        if (legal) q.push_back('{e + c_L, r - 4, c - 4});

        @(posedge clk);
        #1;
        cyc++;
        start = 1'b0;
        if (st && idle) begin
            stream_on = 1'b1;
            pix_r     = 0;
            pix_c     = 0;
        end

        chk("win_valid", 150'(win_valid), 150'(legal));
        if (win_valid === 1'b1) begin
            if (n_wdut == 0) begin
                chk("first_win_at_pixel", 150'(n_acc), 150'(133));
                if (mode == 0) begin
                    chk("first_tap04", 150'(win_data[29:24]), 150'(8));
                    chk("first_tap40", 150'(win_data[125:120]), 150'(0));
                    chk("first_tap22", 150'(win_data[77:72]), 150'(4));
                end
            end
            n_wdut++;
        end
        if (legal) begin
            chk("win_data", win_data, model_win(mode, r, c));
            if (r == 5 && c == 4) chk("wrap_tap00", 150'(win_data[5:0]), 150'(pix(mode, 5, 0)));
        end

        cv_exp = (q.size() > 0) && (q[0].due == cyc);
        chk("conv_valid", 150'(conv_valid), 150'(cv_exp));
        if (cv_exp) begin
            last_or = q[0].orow;
            last_oc = q[0].ocol;
            void'(q.pop_front());
        end
        chk("out_row", 150'(out_row), 150'(last_or));
        chk("out_col", 150'(out_col), 150'(last_oc));
        chk("frame_done", 150'(frame_done), 150'(cyc == fd_due));
        chk("busy", 150'(busy), 150'(stream_on || (fd_due >= 0 && cyc <= fd_due)));
        if (frame_done === 1'b1) n_fd++;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        rst       = 1'b0;
        stream_on = 1'b0;
        fd_due    = -1;
        last_or   = 0;
        last_oc   = 0;
        q.delete();
        chk("rst_win_data", win_data, 150'(0));
        chk("rst_win_valid", 150'(win_valid), 150'(0));
        chk("rst_conv_valid", 150'(conv_valid), 150'(0));
        chk("rst_out_row", 150'(out_row), 150'(0));
        chk("rst_out_col", 150'(out_col), 150'(0));
        chk("rst_busy", 150'(busy), 150'(0));
        chk("rst_frame_done", 150'(frame_done), 150'(0));
        chk("rst_in_ready", 150'(in_ready), 150'(0));
    endtask

    task automatic run_frame(input int m, input bit stall, input int abort_at);
        int guard;
        mode   = m;
        n_acc  = 0;
        n_wdut = 0;
        n_fd   = 0;
        guard  = 0;
        tick(1'b1, 1'b0);
        while (stream_on && guard < 8000) begin
            if (abort_at >= 0 && n_acc == abort_at) begin
                do_reset();
                repeat (c_L + 4) tick(1'b0, 1'b0);
                chk("abort_no_done", 150'(n_fd), 150'(0));
                return;
            end
            tick(n_acc == 200, stall ? 1'($urandom_range(0, 1)) : 1'b1);
            guard++;
        end
        chk("stream_bound", 150'(stream_on), 150'(0));
        // Start during drain must be ignored.
        tick(1'b1, 1'b0);
        for (int k = 0; k < c_L + 4; k++) tick(1'b0, 1'b0);
        chk("win_count", 150'(n_wdut), 150'(784));
        chk("done_count", 150'(n_fd), 150'(1));
        chk("last_out_row", 150'(out_row), 150'(27));
        chk("last_out_col", 150'(out_col), 150'(27));
    endtask

    initial begin
        do_reset();
        repeat (3) tick(1'b0, 1'b1);
        run_frame(0, 1'b0, -1);
        run_frame(1, 1'b1, -1);
        run_frame(1, 1'b0, 400);
        run_frame(0, 1'b0, -1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
